uart_alu_ctrl: RTL

UART_ALU_CTRL -- requirements
Module: uart_alu_ctrl

---
 rtl/uart_alu_pkg.sv | 77 +++++++
 rtl/bin_to_ascii3.sv | 37 +++
 rtl/uart_alu_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_alu_pkg
// Purpose  : Shared definitions for the UART ALU command controller.
//            - ASCII command, operator and line-ending characters
//            - ALU opcode values
//            - Controller FSM state encoding
//            - Helper that maps an operator character to an ALU opcode
// Revision : 1.0  initial release
// ============================================================================
package uart_alu_pkg;

    // Command characters
    localparam logic [7:0] c_ASCII_0  = 8'h30;
    localparam logic [7:0] c_ASCII_9  = 8'h39;
    localparam logic [7:0] c_CMD_F    = 8'h66;  // load operand A
    localparam logic [7:0] c_CMD_S    = 8'h73;  // load operand B
    localparam logic [7:0] c_CMD_O    = 8'h6F;  // commit pending operator
    localparam logic [7:0] c_CMD_D    = 8'h64;  // transmit the result
    localparam logic [7:0] c_ASCII_CR = 8'h0D;
    localparam logic [7:0] c_ASCII_LF = 8'h0A;

    // Operator characters
    localparam logic [7:0] c_CH_ADD = 8'h2B;  // '+'
    localparam logic [7:0] c_CH_SUB = 8'h2D;  // '-'
    localparam logic [7:0] c_CH_AND = 8'h26;  // '&'
    localparam logic [7:0] c_CH_OR  = 8'h7C;  // '|'
    localparam logic [7:0] c_CH_XOR = 8'h78;  // 'x'
    localparam logic [7:0] c_CH_SRA = 8'h61;  // 'a'
    localparam logic [7:0] c_CH_SRL = 8'h6C;  // 'l'
    localparam logic [7:0] c_CH_NOR = 8'h6E;  // 'n'

    // ALU opcodes
    localparam logic [5:0] c_OP_ADD = 6'd32;
    localparam logic [5:0] c_OP_SUB = 6'd34;
    localparam logic [5:0] c_OP_AND = 6'd36;
    localparam logic [5:0] c_OP_OR  = 6'd37;
    localparam logic [5:0] c_OP_XOR = 6'd38;
    localparam logic [5:0] c_OP_SRA = 6'd3;
    localparam logic [5:0] c_OP_SRL = 6'd2;
    localparam logic [5:0] c_OP_NOR = 6'd39;
    localparam logic [5:0] c_OP_BAD = 6'd63;

    // Controller states
    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_CONVERT = 2'd1,
        S_SEND    = 2'd2,
        S_WAIT    = 2'd3
    } state_t;

    typedef struct packed {
        logic       vld;
        logic [5:0] op;
    } op_dec_t;

    // Operator character -> opcode; vld is low for anything else.
    function automatic op_dec_t decode_op(input logic [7:0] ch);
        op_dec_t dec;
        dec.vld = 1'b1;
        dec.op  = c_OP_BAD;
        case (ch)
            c_CH_ADD: dec.op = c_OP_ADD;
            c_CH_SUB: dec.op = c_OP_SUB;
            c_CH_AND: dec.op = c_OP_AND;
            c_CH_OR:  dec.op = c_OP_OR;
            c_CH_XOR: dec.op = c_OP_XOR;
            c_CH_SRA: dec.op = c_OP_SRA;
            c_CH_SRL: dec.op = c_OP_SRL;
            c_CH_NOR: dec.op = c_OP_NOR;
            default:  dec.vld = 1'b0;
        endcase
        return dec;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin_to_ascii3.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_ascii3
// Purpose  : Combinational binary to three-digit ASCII decimal converter.
// Ports    : i_bin   [NB_DATA-1:0]  binary value
//            o_hund  [DBIT-1:0]     ASCII hundreds digit
//            o_tens  [DBIT-1:0]     ASCII tens digit
//            o_unit  [DBIT-1:0]     ASCII units digit
// Revision : 1.0  initial release
// ============================================================================
module bin_to_ascii3
    import uart_alu_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int DBIT    = 8
) (
    input  logic [NB_DATA-1:0] i_bin,
    output logic [DBIT-1:0]    o_hund,
    output logic [DBIT-1:0]    o_tens,
    output logic [DBIT-1:0]    o_unit
);

    logic [NB_DATA-1:0] w_h;
    logic [NB_DATA-1:0] w_t;
    logic [NB_DATA-1:0] w_u;

    // Division by constants only; synthesis reduces these to fixed logic.
    assign w_h = i_bin / NB_DATA'(100);
    assign w_t = (i_bin / NB_DATA'(10)) % NB_DATA'(10);
    assign w_u = i_bin % NB_DATA'(10);

    assign o_hund = DBIT'(c_ASCII_0) + DBIT'(w_h);
    assign o_tens = DBIT'(c_ASCII_0) + DBIT'(w_t);
    assign o_unit = DBIT'(c_ASCII_0) + DBIT'(w_u);

endmodule
`default_nettype wire

// File: rtl/uart_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_alu_ctrl
// Purpose  : Parses ASCII commands from a UART receiver into ALU operands and
//            opcode, and returns the ALU result as ASCII decimal digits via a
//            UART transmitter.
// Ports    : clk             system clock, rising edge
//            rst_n           asynchronous reset, active low
//            i_rx_done_tick  received byte strobe
//            i_rx_data       received byte
//            i_tx_done_tick  transmitter finished current byte
//            o_tx_start      one-cycle load strobe for the transmitter
//            o_tx_data       byte to transmit
//            o_alu_a/o_alu_b registered ALU operands
//            o_alu_op        registered ALU opcode
//            i_alu_result    combinational ALU result
//            o_busy          high whenever not collecting commands
//            o_err           last 'o' had no valid operator pending
// Config   : UART_ALU_CRLF_EN  append CR LF after the three result digits
// Revision : 1.0  initial release
// ============================================================================
module uart_alu_ctrl
    import uart_alu_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_rx_done_tick,
    input  logic [DBIT-1:0]    i_rx_data,
    input  logic               i_tx_done_tick,
    output logic               o_tx_start,
    output logic [DBIT-1:0]    o_tx_data,
    output logic [NB_DATA-1:0] o_alu_a,
    output logic [NB_DATA-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic               o_busy,
    output logic               o_err
);

`ifdef UART_ALU_CRLF_EN
    localparam logic [2:0] c_LAST_IDX = 3'd4;
`else
    localparam logic [2:0] c_LAST_IDX = 3'd2;
`endif

    state_t             r_state, w_state_nxt;
    logic [3:0]         r_d2, r_d1, r_d0;
    logic [NB_DATA-1:0] r_alu_a, r_alu_b, r_res;
    logic [NB_OP-1:0]   r_alu_op, r_pend_op;
    logic               r_pend_vld, r_err;
    logic [2:0]         r_idx;

    logic [7:0]         w_ch;
    logic               w_rx_acc, w_is_digit;
    op_dec_t            w_dec;
    logic [9:0]         w_value10;
    logic [NB_DATA-1:0] w_value;
    logic [DBIT-1:0]    w_hund, w_tens, w_unit, w_q_byte;

    assign w_ch       = 8'(i_rx_data);
    assign w_rx_acc   = i_rx_done_tick && (r_state == S_COLLECT);
    assign w_is_digit = (w_ch >= c_ASCII_0) && (w_ch <= c_ASCII_9);
    assign w_dec      = decode_op(w_ch);

    // Max 999 fits in 10 bits; the operand keeps only the low NB_DATA bits.
    assign w_value10 = 10'(r_d2) * 10'd100 + 10'(r_d1) * 10'd10 + 10'(r_d0);
    assign w_value   = NB_DATA'(w_value10);

    // The byte queue is derived from the captured result and the index.
    bin_to_ascii3 #(
        .NB_DATA (NB_DATA),
        .DBIT    (DBIT)
    ) u_bin_to_ascii3 (
        .i_bin  (r_res),
        .o_hund (w_hund),
        .o_tens (w_tens),
        .o_unit (w_unit)
    );

    always_comb begin
        w_q_byte = '0;
        case (r_idx)
            3'd0:    w_q_byte = w_hund;
            3'd1:    w_q_byte = w_tens;
            3'd2:    w_q_byte = w_unit;
`ifdef UART_ALU_CRLF_EN
            3'd3:    w_q_byte = DBIT'(c_ASCII_CR);
            3'd4:    w_q_byte = DBIT'(c_ASCII_LF);
`endif
            default: w_q_byte = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and Moore outputs
    always_comb begin
        w_state_nxt = r_state;
        o_tx_start  = 1'b0;
        o_tx_data   = '0;
        o_busy      = 1'b1;
        case (r_state)
            S_COLLECT: begin
                o_busy = 1'b0;
                if (w_rx_acc && (w_ch == c_CMD_D)) begin
                    w_state_nxt = S_CONVERT;
                end
            end
            S_CONVERT: begin
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                o_tx_start  = 1'b1;
                o_tx_data   = w_q_byte;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                o_tx_data = w_q_byte;
                if (i_tx_done_tick) begin
                    w_state_nxt = (r_idx == c_LAST_IDX) ? S_COLLECT : S_SEND;
                end
            end
            default: begin
                w_state_nxt = S_COLLECT;
            end
        endcase
    end

    // Command datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d2       <= '0;
            r_d1       <= '0;
            r_d0       <= '0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_pend_op  <= '0;
            r_pend_vld <= 1'b0;
            r_err      <= 1'b0;
            r_res      <= '0;
            r_idx      <= '0;
        end else begin
            if (w_rx_acc) begin
                if (w_is_digit) begin
                    r_d2 <= r_d1;
                    r_d1 <= r_d0;
                    r_d0 <= w_ch[3:0];
                end else if (w_ch == c_CMD_F) begin
                    r_alu_a <= w_value;
                    r_d2    <= '0;
                    r_d1    <= '0;
                    r_d0    <= '0;
                end else if (w_ch == c_CMD_S) begin
                    r_alu_b <= w_value;
                    r_d2    <= '0;
                    r_d1    <= '0;
                    r_d0    <= '0;
                end else if (w_ch == c_CMD_O) begin
                    // Each operator character is consumed by one 'o' only.
                    if (r_pend_vld) begin
                        r_alu_op <= r_pend_op;
                        r_err    <= 1'b0;
                    end else begin
                        r_alu_op <= NB_OP'(c_OP_BAD);
                        r_err    <= 1'b1;
                    end
                    r_pend_vld <= 1'b0;
                end else if (w_dec.vld) begin
                    r_pend_op  <= NB_OP'(w_dec.op);
                    r_pend_vld <= 1'b1;
                end
            end

            if (r_state == S_CONVERT) begin
                r_res <= i_alu_result;
                r_idx <= '0;
            end else if ((r_state == S_WAIT) && i_tx_done_tick &&
                         (r_idx != c_LAST_IDX)) begin
                r_idx <= r_idx + 3'd1;
            end
        end
    end

    assign o_alu_a  = r_alu_a;
    assign o_alu_b  = r_alu_b;
    assign o_alu_op = r_alu_op;
    assign o_err    = r_err;

endmodule
`default_nettype wire
